// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse types, timing defaults and the letter table
// Each table entry is {len[2:0], bits[3:0]}; the first symbol sent sits in the highest used bit.
package morse_pkg;

    typedef enum logic {
        DOT  = 1'b0,
        DASH = 1'b1
    } sym_t;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        ERR_WAIT
    } state_t;

    localparam int DOT_CYCLES_DEF        = 100;
    localparam int DASH_CYCLES_DEF       = 200;
    localparam int LETTER_GAP_CYCLES_DEF = 300;
    localparam int CNT_W_DEF             = 10;
    localparam int MAX_SYMS_DEF          = 4;
    localparam int N_LETTERS             = 26;

    localparam logic [6:0] MORSE_LUT [N_LETTERS] = '{
        7'b010_0001,  // A .-
        7'b100_1000,  // B -...
        7'b100_1010,  // C -.-.
        7'b011_0100,  // D -..
        7'b001_0000,  // E .
        7'b100_0010,  // F ..-.
        7'b011_0110,  // G --.
        7'b100_0000,  // H ....
        7'b010_0000,  // I ..
        7'b100_0111,  // J .---
        7'b011_0101,  // K -.-
        7'b100_0100,  // L .-..
        7'b010_0011,  // M --
        7'b010_0010,  // N -.
        7'b011_0111,  // O ---
        7'b100_0110,  // P .--.
        7'b100_1101,  // Q --.-
        7'b011_0010,  // R .-.
        7'b011_0000,  // S ...
        7'b001_0001,  // T -
        7'b011_0001,  // U ..-
        7'b100_0001,  // V ...-
        7'b011_0011,  // W .--
        7'b100_1001,  // X -..-
        7'b100_1011,  // Y -.--
        7'b100_1100   // Z --..
    };

    function automatic logic [6:0] lut_key(input logic [2:0] len, input logic [3:0] bits);
        return {len, bits};
    endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// rtl/morse_decoder_if.sv - line input and decoded-letter outputs of the Morse decoder
// master drives the line and enable; slave is the decoder.
interface morse_decoder_if;
    logic       en;
    logic       din;
    logic [4:0] code;
    logic       code_valid;
    logic       code_err;
    logic       busy;

    modport master (
        output en,
        output din,
        input  code,
        input  code_valid,
        input  code_err,
        input  busy
    );

    modport slave (
        input  en,
        input  din,
        output code,
        output code_valid,
        output code_err,
        output busy
    );
endinterface

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - combinational reverse lookup of a collected symbol string
// Searches the shared table for {len, bits}; hit_o is low when no letter matches.
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0] len_i,
    input  logic [3:0] bits_i,
    output logic       hit_o,
    output logic [4:0] idx_o
);

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = 0; i < N_LETTERS; i++) begin
            if (MORSE_LUT[i] == lut_key(len_i, bits_i)) begin
                hit_o = 1'b1;
                idx_o = 5'(i);
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - recovers letter indices from a timed on/off Morse line
// Mark/space durations are measured on the registered line; a long space ends the letter.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int DOT_CYCLES        = DOT_CYCLES_DEF,
    parameter int DASH_CYCLES       = DASH_CYCLES_DEF,
    parameter int LETTER_GAP_CYCLES = LETTER_GAP_CYCLES_DEF,
    parameter int CNT_W             = CNT_W_DEF,
    parameter int MAX_SYMS          = MAX_SYMS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    morse_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] GLITCH_LIM = CNT_W'(DOT_CYCLES / 2);
    localparam logic [CNT_W-1:0] DASH_LIM   = CNT_W'((DOT_CYCLES + DASH_CYCLES) / 2);
    localparam logic [CNT_W-1:0] STUCK_LIM  = CNT_W'(2 * DASH_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LIM    = CNT_W'(LETTER_GAP_CYCLES);
    localparam logic [2:0]       SYM_LIM    = 3'(MAX_SYMS);

    logic             din_q;
    logic             din_prev_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       sym_cnt_q;
    logic [3:0]       shift_q;
    logic [4:0]       code_q;
    logic             code_valid_q;
    logic             code_err_q;
    logic             lut_hit;
    logic [4:0]       lut_idx;
    sym_t             sym_cls;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;
    assign sym_cls = (cnt_q < DASH_LIM) ? DOT : DASH;

    morse_lut u_lut (
        .len_i  (sym_cnt_q),
        .bits_i (shift_q),
        .hit_o  (lut_hit),
        .idx_o  (lut_idx)
    );

    // din_prev_q lets IDLE require a fresh rising edge, so a mark already high when en returns is skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q      <= 1'b0;
            din_prev_q <= 1'b0;
        end else begin
            din_q      <= bus.din;
            din_prev_q <= din_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sym_cnt_q    <= '0;
            shift_q      <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            code_err_q   <= 1'b0;
            if (!bus.en) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                sym_cnt_q <= '0;
                shift_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (din_q && !din_prev_q) begin
                            state_q <= MARK;
                            cnt_q   <= ONE;
                        end
                    end
                    MARK: begin
                        if (din_q) begin
                            if (cnt_inc >= STUCK_LIM) begin
                                code_err_q <= 1'b1;
                                state_q    <= ERR_WAIT;
                                cnt_q      <= '0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else if (cnt_q < GLITCH_LIM || sym_cnt_q == SYM_LIM) begin
                            // The falling-edge cycle is already low, so the error gap starts at 1.
                            code_err_q <= 1'b1;
                            state_q    <= ERR_WAIT;
                            cnt_q      <= ONE;
                        end else begin
                            shift_q   <= {shift_q[2:0], 1'(sym_cls)};
                            sym_cnt_q <= sym_cnt_q + 3'd1;
                            state_q   <= SPACE;
                            cnt_q     <= ONE;
                        end
                    end
                    SPACE: begin
                        if (din_q) begin
                            state_q <= MARK;
                            cnt_q   <= ONE;
                        end else if (cnt_inc >= GAP_LIM) begin
                            if (lut_hit) begin
                                code_q       <= lut_idx;
                                code_valid_q <= 1'b1;
                            end else begin
                                code_err_q <= 1'b1;
                            end
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                            sym_cnt_q <= '0;
                            shift_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    ERR_WAIT: begin
                        if (din_q) begin
                            cnt_q <= '0;
                        end else if (cnt_inc >= GAP_LIM) begin
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                            sym_cnt_q <= '0;
                            shift_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.code_err   = code_err_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - directed self-checking bench for morse_decoder
module tb_morse_decoder;
    import morse_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    morse_decoder_if bus();

    morse_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int n_valid = 0, n_err = 0, n_both = 0;
    int valid_cyc = 0, err_cyc = 0, t_space = 0;
    logic busy_at_valid = 1'b0, busy_before_valid = 1'b0, busy_prev = 1'b0;
    logic [4:0] codes [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.code_valid) begin
            n_valid++;
            codes.push_back(bus.code);
            valid_cyc = cyc;
            busy_at_valid = bus.busy;
            busy_before_valid = busy_prev;
        end
        if (bus.code_err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (bus.code_valid && bus.code_err) n_both++;
        busy_prev = bus.busy;
    end

    task automatic hold(input logic v, input int n);
        bus.din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_letter(input int len, input logic [3:0] bits);
        for (int i = len - 1; i >= 0; i--) begin
            hold(1'b1, bits[i] ? 200 : 100);
            if (i > 0) hold(1'b0, 100);
            else begin
                t_space = cyc;
                hold(1'b0, 300);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.en = 1'b1; bus.din = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.code !== 5'd0) $display("FAIL reset_code got %0d want 0", bus.code); else passed++;
        total++; if (bus.code_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.code_valid); else passed++;
        total++; if (bus.code_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.code_err); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
        rst = 1'b0;
        hold(1'b0, 5);
    endtask

    task automatic test_letter_a;
        int v0 = n_valid, e0 = n_err;
        logic [4:0] c;
        send_letter(2, 4'b0001);
        hold(1'b0, 5);
        c = (codes.size() > 0) ? codes[codes.size()-1] : 5'h1f;
        total++; if (n_valid !== v0 + 1) $display("FAIL a_valid_count got %0d want %0d", n_valid, v0 + 1); else passed++;
        total++; if (c !== 5'd0) $display("FAIL a_code got %0d want 0", c); else passed++;
        total++; if (valid_cyc - t_space !== 301) $display("FAIL a_latency got %0d want 301", valid_cyc - t_space); else passed++;
        total++; if (busy_at_valid !== 1'b0) $display("FAIL a_busy_drop got %b want 0", busy_at_valid); else passed++;
        total++; if (busy_before_valid !== 1'b1) $display("FAIL a_busy_before got %b want 1", busy_before_valid); else passed++;
        total++; if (n_err !== e0) $display("FAIL a_err_count got %0d want %0d", n_err, e0); else passed++;
    endtask

    task automatic test_back_to_back;
        int v0 = n_valid, e0 = n_err, sz = codes.size();
        logic [4:0] c0, c1;
        send_letter(4, 4'b1000);
        send_letter(4, 4'b1010);
        hold(1'b0, 5);
        c0 = (codes.size() > sz) ? codes[sz] : 5'h1f;
        c1 = (codes.size() > sz + 1) ? codes[sz+1] : 5'h1f;
        total++; if (n_valid !== v0 + 2) $display("FAIL bc_valid_count got %0d want %0d", n_valid, v0 + 2); else passed++;
        total++; if (c0 !== 5'd1) $display("FAIL bc_code_b got %0d want 1", c0); else passed++;
        total++; if (c1 !== 5'd2) $display("FAIL bc_code_c got %0d want 2", c1); else passed++;
        total++; if (n_err !== e0) $display("FAIL bc_err_count got %0d want %0d", n_err, e0); else passed++;
    endtask

    task automatic test_glitch;
        int v0 = n_valid, e0 = n_err;
        hold(1'b1, 30);
        hold(1'b0, 305);
        total++; if (n_err !== e0 + 1) $display("FAIL glitch_err got %0d want %0d", n_err, e0 + 1); else passed++;
        total++; if (n_valid !== v0) $display("FAIL glitch_valid got %0d want %0d", n_valid, v0); else passed++;
        total++; if (bus.code !== 5'd2) $display("FAIL glitch_code_hold got %0d want 2", bus.code); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL glitch_idle got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_overflow;
        int v0 = n_valid, e0 = n_err, t;
        for (int i = 0; i < 4; i++) begin
            hold(1'b1, 100);
            hold(1'b0, 100);
        end
        total++; if (n_err !== e0) $display("FAIL ovf_early_err got %0d want %0d", n_err, e0); else passed++;
        hold(1'b1, 100);
        t = cyc;
        hold(1'b0, 250);
        total++; if (n_err !== e0 + 1) $display("FAIL ovf_err got %0d want %0d", n_err, e0 + 1); else passed++;
        total++; if (err_cyc - t !== 2) $display("FAIL ovf_err_time got %0d want 2", err_cyc - t); else passed++;
        total++; if (bus.busy !== 1'b1) $display("FAIL ovf_wait_busy got %b want 1", bus.busy); else passed++;
        hold(1'b0, 55);
        total++; if (bus.busy !== 1'b0) $display("FAIL ovf_idle got %b want 0", bus.busy); else passed++;
        total++; if (n_valid !== v0) $display("FAIL ovf_valid got %0d want %0d", n_valid, v0); else passed++;
    endtask

    task automatic test_stuck;
        int v0 = n_valid, e0 = n_err, t;
        t = cyc;
        hold(1'b1, 450);
        total++; if (n_err !== e0 + 1) $display("FAIL stuck_err got %0d want %0d", n_err, e0 + 1); else passed++;
        total++; if (err_cyc - t !== 401) $display("FAIL stuck_err_time got %0d want 401", err_cyc - t); else passed++;
        total++; if (bus.busy !== 1'b1) $display("FAIL stuck_busy got %b want 1", bus.busy); else passed++;
        hold(1'b0, 305);
        total++; if (bus.busy !== 1'b0) $display("FAIL stuck_idle got %b want 0", bus.busy); else passed++;
        send_letter(2, 4'b0001);
        hold(1'b0, 5);
        total++; if (n_valid !== v0 + 1) $display("FAIL stuck_a_valid got %0d want %0d", n_valid, v0 + 1); else passed++;
        total++; if (bus.code !== 5'd0) $display("FAIL stuck_a_code got %0d want 0", bus.code); else passed++;
        total++; if (n_err !== e0 + 1) $display("FAIL stuck_a_err got %0d want %0d", n_err, e0 + 1); else passed++;
    endtask

    task automatic test_en_rst;
        int v0, e0;
        send_letter(1, 4'b0001);
        hold(1'b0, 5);
        total++; if (bus.code !== 5'd19) $display("FAIL t_code got %0d want 19", bus.code); else passed++;
        v0 = n_valid; e0 = n_err;
        hold(1'b1, 200);
        hold(1'b0, 100);
        hold(1'b1, 100);
        hold(1'b0, 50);
        total++; if (bus.busy !== 1'b1) $display("FAIL en_busy_mid got %b want 1", bus.busy); else passed++;
        bus.en = 1'b0;
        hold(1'b0, 2);
        total++; if (bus.busy !== 1'b0) $display("FAIL en_drop_idle got %b want 0", bus.busy); else passed++;
        bus.en = 1'b1;
        hold(1'b0, 300);
        hold(1'b1, 20);
        bus.en = 1'b0;
        hold(1'b1, 2);
        bus.en = 1'b1;
        hold(1'b1, 100);
        total++; if (bus.busy !== 1'b0) $display("FAIL en_mark_ignored got %b want 0", bus.busy); else passed++;
        hold(1'b0, 310);
        total++; if (n_valid !== v0 || n_err !== e0)
            $display("FAIL en_no_pulse got v%0d e%0d want v%0d e%0d", n_valid, n_err, v0, e0); else passed++;
        hold(1'b1, 50);
        total++; if (bus.busy !== 1'b1) $display("FAIL rst_pre_busy got %b want 1", bus.busy); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (bus.code !== 5'd0) $display("FAIL rst_code got %0d want 0", bus.code); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else passed++;
        total++; if (bus.code_valid !== 1'b0 || bus.code_err !== 1'b0)
            $display("FAIL rst_pulses got v%b e%b want 0 0", bus.code_valid, bus.code_err); else passed++;
        bus.din = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b0, 20);
        total++; if (n_valid !== v0 || n_err !== e0)
            $display("FAIL rst_no_pulse got v%0d e%0d want v%0d e%0d", n_valid, n_err, v0, e0); else passed++;
        send_letter(2, 4'b0001);
        hold(1'b0, 5);
        total++; if (n_valid !== v0 + 1) $display("FAIL rst_a_valid got %0d want %0d", n_valid, v0 + 1); else passed++;
        total++; if (bus.code !== 5'd0) $display("FAIL rst_a_code got %0d want 0", bus.code); else passed++;
        total++; if (n_err !== e0) $display("FAIL rst_a_err got %0d want %0d", n_err, e0); else passed++;
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_back_to_back();
        test_glitch();
        test_overflow();
        test_stuck();
        test_en_rst();
        total++; if (n_both !== 0) $display("FAIL exclusive_pulses got %0d want 0", n_both); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
